// File: rtl/decode_imm_scheduler.sv
// Instruction-decode stage front end: selects the immediate format for an external
// immediate generator and stages decoded entries in a main + skid register pair.
module decode_imm_scheduler #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_pc,
    input  logic                   flush,
    output logic [31:0]            gen_instr,
    output logic [2:0]             gen_sel,
    input  logic [31:0]            gen_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_imm,
    output logic                   out_illegal,
    output logic [COUNT_WIDTH-1:0] illegal_count
);

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_J = 3'b011;
    localparam logic [2:0] SEL_U = 3'b100;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic        in_illegal;
    logic        in_zero_imm;
    logic [31:0] in_imm;

    logic        main_valid;
    logic [31:0] main_instr;
    logic [31:0] main_pc;
    logic [31:0] main_imm;
    logic        main_illegal;

    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] skid_imm;
    logic        skid_illegal;

    logic        accept;
    logic        consume;
    logic        main_free;
    logic        load_main_from_skid;
    logic        load_main_from_in;
    logic        load_skid;

    assign gen_instr = in_instr;

    always_comb begin
        gen_sel     = SEL_I;
        in_illegal  = 1'b0;
        in_zero_imm = 1'b0;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: gen_sel = SEL_I;
            OP_REG: begin
                gen_sel     = SEL_I;
                in_zero_imm = 1'b1;
            end
            OP_STORE:         gen_sel = SEL_S;
            OP_BRANCH:        gen_sel = SEL_B;
            OP_JAL:           gen_sel = SEL_J;
            OP_LUI, OP_AUIPC: gen_sel = SEL_U;
            default: begin
                gen_sel    = SEL_I;
                in_illegal = 1'b1;
            end
        endcase
    end

    // R-type and unknown opcodes carry no immediate; never trust the generator for them.
    assign in_imm = (in_illegal || in_zero_imm) ? 32'd0 : gen_imm;

    // in_ready depends only on registered state so out_ready never reaches upstream.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = main_valid & out_ready;
    assign main_free = ~main_valid | consume;

    always_comb begin
        load_main_from_skid = 1'b0;
        load_main_from_in   = 1'b0;
        load_skid           = 1'b0;
        if (!flush) begin
            if (main_free) begin
                load_main_from_skid = skid_valid;
                load_main_from_in   = ~skid_valid & accept;
                load_skid           = skid_valid & accept;
            end else begin
                load_skid = accept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            main_valid <= skid_valid | accept;
            skid_valid <= skid_valid & accept;
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr   <= '0;
            main_pc      <= '0;
            main_imm     <= '0;
            main_illegal <= 1'b0;
        end else if (load_main_from_skid) begin
            main_instr   <= skid_instr;
            main_pc      <= skid_pc;
            main_imm     <= skid_imm;
            main_illegal <= skid_illegal;
        end else if (load_main_from_in) begin
            main_instr   <= in_instr;
            main_pc      <= in_pc;
            main_imm     <= in_imm;
            main_illegal <= in_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
        end else if (load_skid) begin
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
            skid_imm     <= in_imm;
            skid_illegal <= in_illegal;
        end
    end

    // Counts accepted illegal words; flush does not undo the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (accept && in_illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + COUNT_ONE;
        end
    end

    assign out_valid   = main_valid;
    assign out_instr   = main_instr;
    assign out_pc      = main_pc;
    assign out_imm     = main_imm;
    assign out_illegal = main_illegal;

endmodule

// File: tb/tb_decode_imm_scheduler.sv
// Directed + randomized bench for decode_imm_scheduler with a behavioural immediate
// generator and an in-order scoreboard of expected entries.
module tb_decode_imm_scheduler;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = 32'd0;
    logic [31:0]   in_pc = 32'd0;
    logic          flush = 1'b0;
    logic [31:0]   gen_instr;
    logic [2:0]    gen_sel;
    logic [31:0]   gen_imm;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_imm;
    logic          out_illegal;
    logic [CW-1:0] illegal_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    decode_imm_scheduler #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .gen_instr(gen_instr), .gen_sel(gen_sel), .gen_imm(gen_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Behavioural immediate generator driven by the DUT's format select.
    always_comb begin
        case (gen_sel)
            3'b000:  gen_imm = {{20{gen_instr[31]}}, gen_instr[31:20]};
            3'b001:  gen_imm = {{20{gen_instr[31]}}, gen_instr[31:25], gen_instr[11:7]};
            3'b010:  gen_imm = {{20{gen_instr[31]}}, gen_instr[7], gen_instr[30:25], gen_instr[11:8], 1'b0};
            3'b011:  gen_imm = {{12{gen_instr[31]}}, gen_instr[19:12], gen_instr[20], gen_instr[30:21], 1'b0};
            3'b100:  gen_imm = {gen_instr[31:12], 12'h000};
            default: gen_imm = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [2:0] ref_sel(input logic [31:0] i);
        case (i[6:0])
            7'b0100011:             ref_sel = 3'b001;
            7'b1100011:             ref_sel = 3'b010;
            7'b1101111:             ref_sel = 3'b011;
            7'b0110111, 7'b0010111: ref_sel = 3'b100;
            default:                ref_sel = 3'b000;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0110011,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111: ref_ill = 1'b0;
            default: ref_ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:
                ref_imm = {{20{i[31]}}, i[31:20]};
            7'b0100011: ref_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: ref_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'b1101111: ref_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            7'b0110111, 7'b0010111: ref_imm = {i[31:12], 12'h000};
            default: ref_imm = 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    // Scoreboard: pop on each consuming edge, push on each accepting edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid) check("gen_sel", {29'd0, gen_sel}, {29'd0, ref_sel(in_instr)});
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_output: observed instr %h expected no entry", out_instr);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_instr", out_instr, mon_e.instr);
                    check("out_pc", out_pc, mon_e.pc);
                    check("out_imm", out_imm, mon_e.imm);
                    check("out_illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
                end
            end
            if (in_valid && in_ready && !flush)
                sb.push_back('{in_instr, in_pc, ref_imm(in_instr), ref_ill(in_instr)});
        end
    end

    logic [31:0] seq_instr [4];
    logic [31:0] seq_imm [4];
    logic [6:0]  ops [12];
    logic [31:0] rnd;

    initial begin
        seq_instr[0] = 32'hFE112E23; seq_imm[0] = 32'hFFFFFFFC;
        seq_instr[1] = 32'hFE000EE3; seq_imm[1] = 32'hFFFFFFFC;
        seq_instr[2] = 32'hFF5FF0EF; seq_imm[2] = 32'hFFFFFFF4;
        seq_instr[3] = 32'h123450B7; seq_imm[3] = 32'h12345000;
        ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2]  = 7'b1100111; ops[3]  = 7'b1110011;
        ops[4] = 7'b0001111; ops[5] = 7'b0110011; ops[6]  = 7'b0100011; ops[7]  = 7'b1100011;
        ops[8] = 7'b1101111; ops[9] = 7'b0110111; ops[10] = 7'b0010111; ops[11] = 7'b1111111;

        // Reset
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_illegal_count", {30'd0, illegal_count}, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // addi x1,x0,-1 with one-cycle latency
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0000_0000;
        check("addi_gen_sel", {29'd0, gen_sel}, 32'd0);
        step();
        in_valid = 1'b0;
        check("addi_out_valid", {31'd0, out_valid}, 32'd1);
        check("addi_out_imm", out_imm, 32'hFFFFFFFF);
        check("addi_out_illegal", {31'd0, out_illegal}, 32'd0);
        drain();

        // Back-to-back S/B/J/U
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = seq_instr[k]; in_pc = 32'h40 + 32'(4 * k);
            step();
            check("b2b_out_imm", out_imm, seq_imm[k]);
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: two held, third waits upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h100;
        step();
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready_after_first", {31'd0, in_ready}, 32'd1);
        in_instr = 32'h00200113; in_pc = 32'h104;
        step();
        check("bp_ready_after_second", {31'd0, in_ready}, 32'd0);
        in_instr = 32'h00300193; in_pc = 32'h108;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_instr", out_instr, 32'h00100093);
        end
        out_ready = 1'b1;
        step();
        check("bp_second_out", out_instr, 32'h00200113);
        check("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_third_out", out_instr, 32'h00300193);
        drain();

        // Flush with both entries full and an incoming word
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h200;
        step();
        in_instr = 32'h00600313; in_pc = 32'h204;
        step();
        check("fl_full_ready", {31'd0, in_ready}, 32'd0);
        in_instr = 32'h00700393; in_pc = 32'h208; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("fl_dropped", {31'd0, out_valid}, 32'd0);

        // Illegal opcode saturation with a 2-bit counter
        check("ill_count_start", {30'd0, illegal_count}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_instr = 32'hABCDE07F; in_pc = 32'h300 + 32'(4 * k);
            step();
            check("ill_out_illegal", {31'd0, out_illegal}, 32'd1);
            check("ill_out_imm", out_imm, 32'd0);
            check("ill_count", {30'd0, illegal_count}, (k > 3) ? 32'd3 : 32'(k));
        end
        in_valid = 1'b0;
        drain();

        // Randomized traffic checked by the scoreboard
        for (int k = 0; k < 80; k++) begin
            rnd = $urandom();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = {rnd[31:7], ops[$urandom_range(0, 11)]};
            in_pc     = 32'h1000 + 32'(4 * k);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Asynchronous reset while entries are held
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h400;
        step();
        in_instr = 32'h00800413; in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        check("ar_held", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_illegal_count", {30'd0, illegal_count}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        check("ar_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("ar_release_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_imm_scheduler.md
DECODE_IMM_SCHEDULER -- requirements
Module: decode_imm_scheduler

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream (IF/ID) instruction valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have port in_instr  input  32  raw instruction word.
REQ-007 SHALL have port in_pc  input  32  PC of in_instr.
REQ-008 SHALL have port flush  input  1  discard all held instructions (branch redirect).
REQ-009 SHALL have port gen_instr  output  32  instruction driven to the immediate generator; equals in_instr.
REQ-010 SHALL have port gen_sel  output  3  immediate type select driven to the immediate generator.
REQ-011 SHALL have port gen_imm  input  32  immediate returned combinationally by the immediate generator.
REQ-012 SHALL have port out_valid  output  1  downstream (ID/EX) entry valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-014 SHALL have ports out_instr, out_pc, out_imm  output  32 each  held instruction, PC, immediate.
REQ-015 SHALL have port out_illegal  output  1  held instruction has an unsupported opcode.
REQ-016 SHALL have port illegal_count  output  COUNT_WIDTH  saturating count of accepted illegal instructions.

Function
REQ-017 SHALL derive gen_sel combinationally from in_instr[6:0]: 0010011/0000011/1100111/1110011/0001111/0110011 -> 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 1101111 -> 011 (J); 0110111/0010111 -> 100 (U); any other -> 000 with illegal flag set.
REQ-018 SHALL capture the immediate as 0 for opcode 0110011 (R-type) and for illegal opcodes, otherwise gen_imm, at the accept edge.
REQ-019 SHALL hold two entries: main (drives out_*) and skid; each entry = {valid, instr, pc, imm, illegal}.
REQ-020 SHALL drive in_ready = NOT skid.valid, from registered state only (no combinational path from out_ready).
REQ-021 SHALL accept when in_valid AND in_ready AND NOT flush; consume when out_valid AND out_ready.
REQ-022 SHALL drive out_valid = main.valid; out_* come directly from main registers.
REQ-023 When main is empty or consumed: if skid valid, main <= skid and skid <= accepted entry (else invalid); if skid empty, main <= accepted entry (else invalid).
REQ-024 When main is valid and not consumed: an accepted entry loads skid; main holds unchanged.
REQ-025 Latency SHALL be 1 cycle: an entry accepted at edge N with main empty appears on out_* after edge N.
REQ-026 SHALL preserve program order; no entry dropped or duplicated except by flush.
REQ-027 flush SHALL invalidate main and skid at the next edge, override simultaneous accept/consume, and make in_ready 1 after that edge.
REQ-028 illegal_count SHALL increment by 1 on each accepted illegal entry, saturate at all-ones, and be unaffected by flush.
REQ-029 With skid valid and out_ready low, main and skid SHALL hold indefinitely (in_ready = 0).

Reset
REQ-030 On rst high, main.valid, skid.valid, out_instr, out_pc, out_imm, out_illegal, illegal_count SHALL clear to 0 immediately, independent of clk.
REQ-031 After rst release, in_ready SHALL be 1 and out_valid 0; rst mid-transfer SHALL drop all held entries.

Verification
REQ-032 Stream addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, gen_sel=000, out_illegal=0.
REQ-033 Back-to-back sw (0xFE112E23), beq (0xFE000EE3), jal (0xFF5FF0EF), lui (0x123450B7) -> out_imm 0xFFFFFFFC, 0xFFFFFFFC, 0xFFFFFFF4, 0x12345000 in order.
REQ-034 out_ready=0, push 3 instructions -> first two held, in_ready=0 after second accept, third held upstream; raise out_ready -> all three emerge in order, no loss.
REQ-035 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming instruction dropped.
REQ-036 Push opcode 0x7F repeatedly with COUNT_WIDTH=2 -> out_illegal=1, out_imm=0, illegal_count 1,2,3,3.
REQ-037 Assert rst asynchronously while entries held -> out_valid and illegal_count read 0 before next clk edge.
